// File: rtl/ascon_ctrl_pkg.sv
// ascon_ctrl_pkg: shared states, mode codes and limits for the Ascon sequencer
package ascon_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_AD_LOAD, S_AD_X1, S_AD_X2, S_MSG_LOAD, S_MSG_X1,
    S_MSG_X2, S_MSG_OUT, S_FINAL, S_TAG, S_SQ_X1, S_SQ_X2, S_SQ_OUT
  } state_t;
  localparam logic [1:0] MODE_ENC = 2'd0;
  localparam logic [1:0] MODE_DEC = 2'd1;
  localparam logic [1:0] MODE_HASH = 2'd2;
  localparam logic [1:0] SEL_AEAD = 2'b00;
  localparam logic [1:0] SEL_HASH = 2'b10;
  localparam int BLK_BYTES = 16;
  localparam logic [31:0] MAX_LEN = 32'hFFFF_FFF0;
endpackage

// File: rtl/ascon_blk_counter.sv
// ascon_blk_counter: block byte position, last-block detect and byte-valid mask
module ascon_blk_counter import ascon_ctrl_pkg::*; #(
  parameter int BLK = BLK_BYTES
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clr,
  input  logic           i_step,
  input  logic [31:0]    i_len,
  output logic [31:0]    o_pos,
  output logic           o_last,
  output logic [BLK-1:0] o_mask
);
  logic [31:0] r_pos;
  logic [31:0] w_rem;
  always_ff @(posedge clk) begin
    if (!rst_n) r_pos <= '0;
    else if (i_clr) r_pos <= '0;
    else if (i_step) r_pos <= r_pos + 32'(BLK);
  end
  assign w_rem = i_len - r_pos;
  assign o_pos = r_pos;
  assign o_last = r_pos + 32'(BLK) >= i_len;
  for (genvar i = 0; i < BLK; i++) begin : g_mask
    assign o_mask[i] = w_rem > 32'(i);
  end
endmodule

// File: rtl/ascon_ctrl.sv
// ascon_ctrl: command/stream sequencer driving ascon_core strobes in legal order
module ascon_ctrl import ascon_ctrl_pkg::*; #(
  parameter int BLK_BYTES = 16,
  parameter int HASH_BLOCKS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_mode,
  input  logic [31:0]  cmd_ad_len,
  input  logic [31:0]  cmd_msg_len,
  input  logic [127:0] tag_expected,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         tag_valid,
  output logic [127:0] tag_out,
  output logic         tag_ok,
  output logic         busy,
  output logic         err,
  output logic [1:0]   core_sel_type,
  output logic         core_mode_sel,
  output logic [31:0]  core_data_length,
  output logic [31:0]  core_data_position,
  output logic [127:0] core_data_in,
  input  logic [127:0] core_data_out,
  input  logic [127:0] core_tag,
  output logic         core_en_init,
  output logic         core_en_ae_am,
  output logic         core_en_encdec,
  output logic         core_en_hash,
  output logic         core_en_final
);
  state_t r_state, w_next;
  logic [1:0] r_mode;
  logic [31:0] r_ad_len, r_msg_len;
  logic [127:0] r_tag_exp, r_blk, r_out, r_tag;
  logic r_last, r_tag_ok, r_err;
  logic [7:0] r_sq;
  logic w_hash, w_ad_ph, w_load, w_acc, w_bad, w_clr, w_step, w_last;
  logic [31:0] w_len, w_pos;
  logic [BLK_BYTES-1:0] w_mask;
  logic [127:0] w_masked;
  assign w_hash = r_mode == MODE_HASH;
  assign w_ad_ph = r_state == S_AD_LOAD || r_state == S_AD_X1 || r_state == S_AD_X2;
  assign w_load = r_state == S_AD_LOAD || r_state == S_MSG_LOAD;
  // hash input travels the AD path, so its length stands in for ad_len there
  assign w_len = (w_ad_ph && !w_hash) ? r_ad_len : r_msg_len;
  assign w_acc = cmd_valid && r_state == S_IDLE;
  assign w_bad = cmd_mode == 2'd3 || cmd_msg_len > MAX_LEN || (cmd_mode != MODE_HASH && cmd_ad_len > MAX_LEN);
  assign w_clr = r_state == S_INIT || (r_state == S_AD_X2 && w_last);
  assign w_step = (r_state == S_AD_X2 && !w_last) || (r_state == S_MSG_OUT && out_ready && !r_last);
  ascon_blk_counter #(.BLK(BLK_BYTES)) u_cnt (
    .clk(clk), .rst_n(rst_n), .i_clr(w_clr), .i_step(w_step), .i_len(w_len),
    .o_pos(w_pos), .o_last(w_last), .o_mask(w_mask)
  );
  for (genvar b = 0; b < BLK_BYTES; b++) begin : g_byte
    assign w_masked[127-8*b -: 8] = w_mask[b] ? core_data_out[127-8*b -: 8] : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    in_ready = 1'b0;
    out_valid = 1'b0;
    core_en_init = 1'b0;
    core_en_ae_am = 1'b0;
    core_en_encdec = 1'b0;
    core_en_hash = 1'b0;
    core_en_final = 1'b0;
    case (r_state)
      S_IDLE: w_next = (w_acc && !w_bad) ? S_INIT : S_IDLE;
      S_INIT: begin
        core_en_init = 1'b1;
        w_next = (!w_hash && r_ad_len == '0) ? S_MSG_LOAD : S_AD_LOAD;
      end
      S_AD_LOAD: begin
        in_ready = w_len != '0;
        w_next = (in_valid || w_len == '0) ? S_AD_X1 : S_AD_LOAD;
      end
      S_AD_X1: begin
        core_en_ae_am = 1'b1;
        w_next = S_AD_X2;
      end
      S_AD_X2: begin
        core_en_ae_am = 1'b1;
        w_next = !w_last ? S_AD_LOAD : w_hash ? S_SQ_X1 : S_MSG_LOAD;
      end
      S_MSG_LOAD: begin
        in_ready = w_len != '0;
        w_next = (in_valid || w_len == '0) ? S_MSG_X1 : S_MSG_LOAD;
      end
      S_MSG_X1: begin
        core_en_encdec = 1'b1;
        w_next = S_MSG_X2;
      end
      S_MSG_X2: begin
        core_en_encdec = 1'b1;
        w_next = (r_msg_len == '0) ? S_FINAL : S_MSG_OUT;
      end
      S_MSG_OUT: begin
        out_valid = 1'b1;
        w_next = !out_ready ? S_MSG_OUT : r_last ? S_FINAL : S_MSG_LOAD;
      end
      S_FINAL: begin
        core_en_final = 1'b1;
        w_next = S_TAG;
      end
      S_TAG: w_next = S_IDLE;
      S_SQ_X1: begin
        core_en_hash = 1'b1;
        w_next = S_SQ_X2;
      end
      S_SQ_X2: begin
        core_en_hash = 1'b1;
        w_next = S_SQ_OUT;
      end
      S_SQ_OUT: begin
        out_valid = 1'b1;
        w_next = !out_ready ? S_SQ_OUT : r_last ? S_IDLE : S_SQ_X1;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode <= MODE_ENC;
      r_ad_len <= '0;
      r_msg_len <= '0;
      r_tag_exp <= '0;
      r_blk <= '0;
      r_out <= '0;
      r_tag <= '0;
      r_last <= 1'b0;
      r_tag_ok <= 1'b0;
      r_err <= 1'b0;
      r_sq <= '0;
    end else begin
      r_err <= w_acc && w_bad;
      if (w_acc && !w_bad) begin
        r_mode <= cmd_mode;
        r_ad_len <= cmd_ad_len;
        r_msg_len <= cmd_msg_len;
        r_tag_exp <= tag_expected;
        r_tag <= '0;
        r_tag_ok <= 1'b0;
      end
      if (w_load) r_blk <= (w_len == '0) ? '0 : in_valid ? in_data : r_blk;
      if (r_state == S_MSG_X2) begin
        r_out <= w_masked;
        r_last <= w_last;
      end
      if (r_state == S_SQ_X2) begin
        r_out <= {core_data_out[63:0], 64'b0};
        r_last <= r_sq == 8'(HASH_BLOCKS - 1);
      end
      if (r_state == S_INIT) r_sq <= '0;
      else if (r_state == S_SQ_OUT && out_ready) r_sq <= r_sq + 8'd1;
      if (r_state == S_FINAL) begin
        r_tag <= core_tag;
        r_tag_ok <= r_mode == MODE_DEC && core_tag == r_tag_exp;
      end
    end
  end
  assign cmd_ready = r_state == S_IDLE;
  assign busy = r_state != S_IDLE;
  assign err = r_err;
  assign out_data = r_out;
  assign out_last = r_last && out_valid;
  assign tag_valid = r_state == S_TAG;
  assign tag_out = r_tag;
  assign tag_ok = r_tag_ok;
  assign core_sel_type = w_hash ? SEL_HASH : SEL_AEAD;
  assign core_mode_sel = r_mode == MODE_DEC;
  assign core_data_length = w_len;
  assign core_data_position = w_pos;
  assign core_data_in = r_blk;
endmodule

// File: tb/tb_ascon_ctrl.sv
// tb_ascon_ctrl: directed self-checking bench against an XOR-keystream core stand-in
module tb_ascon_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_mode = '0;
  logic [31:0] cmd_ad_len = '0, cmd_msg_len = '0;
  logic [127:0] tag_expected = '0;
  logic in_valid = 1'b0, in_ready;
  logic [127:0] in_data = '0;
  logic out_valid, out_ready = 1'b0, out_last;
  logic [127:0] out_data;
  logic tag_valid, tag_ok, busy, err;
  logic [127:0] tag_out;
  logic [1:0] core_sel_type;
  logic core_mode_sel;
  logic [31:0] core_data_length, core_data_position;
  logic [127:0] core_data_in, core_data_out, core_tag;
  logic core_en_init, core_en_ae_am, core_en_encdec, core_en_hash, core_en_final;
  localparam logic [127:0] TAGC = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [127:0] P0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] P1 = 128'hCAFEF00D_11111111_22222222_33333333;
  localparam logic [127:0] A0 = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
  // squeeze of an all-zero block at position 0: ks(0)[63:0] = 12345678_DEADBEEF
  localparam logic [127:0] SQ_EXP = 128'h12345678_DEADBEEF_00000000_00000000;
  always #5 clk = ~clk;
  ascon_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_ad_len(cmd_ad_len), .cmd_msg_len(cmd_msg_len),
    .tag_expected(tag_expected), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .tag_valid(tag_valid),
    .tag_out(tag_out), .tag_ok(tag_ok), .busy(busy), .err(err),
    .core_sel_type(core_sel_type), .core_mode_sel(core_mode_sel),
    .core_data_length(core_data_length), .core_data_position(core_data_position),
    .core_data_in(core_data_in), .core_data_out(core_data_out), .core_tag(core_tag),
    .core_en_init(core_en_init), .core_en_ae_am(core_en_ae_am),
    .core_en_encdec(core_en_encdec), .core_en_hash(core_en_hash),
    .core_en_final(core_en_final)
  );
  function automatic logic [127:0] ks(input logic [31:0] p);
    return {p, ~p, p ^ 32'h1234_5678, 32'hDEAD_BEEF};
  endfunction
  function automatic logic [127:0] keep(input logic [127:0] d, input int n);
    logic [127:0] m;
    m = '1;
    return d & ~(m >> (8 * n));
  endfunction
  assign core_data_out = core_data_in ^ ks(core_data_position);
  assign core_tag = TAGC;
  int n_tests = 0, n_fail = 0;
  int c_init = 0, c_aeam = 0, c_encdec = 0, c_hash = 0, c_final = 0, c_multi = 0, c_inrdy = 0, c_tagv = 0;
  logic [31:0] aeam_len = 32'hFFFF_FFFF;
  always @(posedge clk) begin
    c_init <= c_init + int'(core_en_init);
    c_aeam <= c_aeam + int'(core_en_ae_am);
    c_encdec <= c_encdec + int'(core_en_encdec);
    c_hash <= c_hash + int'(core_en_hash);
    c_final <= c_final + int'(core_en_final);
    c_inrdy <= c_inrdy + int'(in_ready);
    c_tagv <= c_tagv + int'(tag_valid);
    if (int'(core_en_init) + int'(core_en_ae_am) + int'(core_en_encdec) + int'(core_en_hash) + int'(core_en_final) > 1)
      c_multi <= c_multi + 1;
    if (core_en_ae_am) aeam_len <= core_data_length;
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_cmd(input logic [1:0] m, input logic [31:0] a, input logic [31:0] l, input logic [127:0] t);
    int w = 0;
    while (!cmd_ready && w < 200) begin tick(); w++; end
    if (w == 200) check("cmd_ready_timeout", 128'(cmd_ready), 128'd1);
    cmd_valid = 1'b1;
    cmd_mode = m;
    cmd_ad_len = a;
    cmd_msg_len = l;
    tag_expected = t;
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic send_blk(input logic [127:0] d);
    int w = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && w < 200) begin tick(); w++; end
    if (w == 200) check("in_ready_timeout", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
  endtask
  task automatic get_beat(output logic [127:0] d, output logic l);
    int w = 0;
    out_ready = 1'b1;
    while (!out_valid && w < 200) begin tick(); w++; end
    if (w == 200) check("out_valid_timeout", 128'(out_valid), 128'd1);
    d = out_data;
    l = out_last;
    tick();
    out_ready = 1'b0;
  endtask
  task automatic finish_tag(input string nm, input logic exp_ok);
    check({nm, "_final_strobe"}, 128'(core_en_final), 128'd1);
    check({nm, "_tagv_early"}, 128'(tag_valid), 128'd0);
    tick();
    check({nm, "_tag_valid"}, 128'(tag_valid), 128'd1);
    check({nm, "_tag_ok"}, 128'(tag_ok), 128'(exp_ok));
    check({nm, "_tag_out"}, tag_out, TAGC);
    tick();
    check({nm, "_idle"}, 128'(busy), 128'd0);
  endtask
  task automatic run_20(input string nm, input logic [1:0] m, input logic [127:0] t,
                        input logic [127:0] b0, input logic [127:0] b1,
                        input logic [127:0] e0, input logic [127:0] e1, input logic exp_ok);
    logic [127:0] d;
    logic l;
    int s_init, s_enc;
    s_init = c_init;
    s_enc = c_encdec;
    send_cmd(m, 32'd0, 32'd20, t);
    check({nm, "_init_n1"}, 128'(core_en_init), 128'd1);
    check({nm, "_mode_sel"}, 128'(core_mode_sel), 128'(m == 2'd1));
    tick();
    check({nm, "_in_ready_n2"}, 128'(in_ready), 128'd1);
    send_blk(b0);
    get_beat(d, l);
    check({nm, "_beat0"}, d, e0);
    check({nm, "_beat0_last"}, 128'(l), 128'd0);
    send_blk(b1);
    get_beat(d, l);
    check({nm, "_beat1"}, d, e1);
    check({nm, "_beat1_last"}, 128'(l), 128'd1);
    finish_tag(nm, exp_ok);
    check({nm, "_init_count"}, 128'(c_init - s_init), 128'd1);
    check({nm, "_encdec_count"}, 128'(c_encdec - s_enc), 128'd4);
  endtask
  initial begin
    logic [127:0] d, c0, c1;
    logic l;
    int s_aeam, s_hash, s_inrdy, s_tagv, bad;
    tick();
    tick();
    check("rst_cmd_ready", 128'(cmd_ready), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_outs", {in_ready, out_valid, out_last, tag_valid, tag_ok, err, core_mode_sel, core_sel_type,
                       core_en_init, core_en_ae_am, core_en_encdec, core_en_hash, core_en_final}, 128'd0);
    check("rst_tag_out", tag_out, 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_core_in", core_data_in, 128'd0);
    rst_n = 1'b1;
    tick();
    // encrypt, ad=0, msg=20: second beat keeps only bytes 0..3
    c0 = P0 ^ ks(32'd0);
    c1 = keep(P1 ^ ks(32'd16), 4);
    run_20("enc", 2'd0, TAGC, P0, P1, c0, c1, 1'b0);
    run_20("dec", 2'd1, TAGC, c0, c1, P0, keep(P1, 4), 1'b1);
    run_20("decbad", 2'd1, TAGC ^ 128'd1, c0, c1, P0, keep(P1, 4), 1'b0);
    s_aeam = c_aeam;
    s_hash = c_hash;
    s_inrdy = c_inrdy;
    s_tagv = c_tagv;
    send_cmd(2'd2, 32'h55, 32'd0, 128'd0);
    check("hash_sel_type", 128'(core_sel_type), 128'd2);
    for (int i = 0; i < 4; i++) begin
      get_beat(d, l);
      check($sformatf("hash_sq%0d", i), d, SQ_EXP);
      check($sformatf("hash_sq%0d_last", i), 128'(l), 128'(i == 3));
    end
    tick();
    check("hash_idle", 128'(busy), 128'd0);
    check("hash_aeam_count", 128'(c_aeam - s_aeam), 128'd2);
    check("hash_aeam_len", 128'(aeam_len), 128'd0);
    check("hash_sq_count", 128'(c_hash - s_hash), 128'd8);
    check("hash_no_in_ready", 128'(c_inrdy - s_inrdy), 128'd0);
    check("hash_no_tag_valid", 128'(c_tagv - s_tagv), 128'd0);
    s_aeam = c_aeam;
    send_cmd(2'd0, 32'd16, 32'd32, 128'd0);
    send_blk(A0);
    send_blk(P0);
    bad = 0;
    for (int w = 0; w < 200 && !out_valid; w++) tick();
    d = out_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_data !== d || !out_valid || core_en_init || core_en_ae_am || core_en_encdec || core_en_hash || core_en_final)
        bad++;
    end
    check("bp_stable", 128'(bad), 128'd0);
    check("bp_beat0", d, P0 ^ ks(32'd0));
    get_beat(d, l);
    send_blk(P1);
    get_beat(d, l);
    check("bp_beat1", d, P1 ^ ks(32'd16));
    check("bp_beat1_last", 128'(l), 128'd1);
    finish_tag("bp", 1'b0);
    check("bp_aeam_count", 128'(c_aeam - s_aeam), 128'd2);
    send_cmd(2'd3, 32'd0, 32'd16, 128'd0);
    check("ill_mode_err", 128'(err), 128'd1);
    check("ill_mode_idle", 128'({busy, cmd_ready}), 128'b01);
    tick();
    check("ill_mode_err_pulse", 128'(err), 128'd0);
    send_cmd(2'd0, 32'd0, 32'hFFFF_FFF1, 128'd0);
    check("ill_len_err", 128'(err), 128'd1);
    check("ill_len_idle", 128'(busy), 128'd0);
    send_cmd(2'd0, 32'd0, 32'hFFFF_FFF0, 128'd0);
    check("max_len_ok", 128'({err, busy}), 128'b01);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("max_len_reset", 128'(busy), 128'd0);
    send_cmd(2'd0, 32'd0, 32'd20, TAGC);
    tick();
    send_blk(P0);
    check("mid_in_x1", 128'(core_en_encdec), 128'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_idle", 128'({busy, cmd_ready, core_en_encdec}), 128'b010);
    run_20("fresh", 2'd0, TAGC, P0, P1, c0, c1, 1'b0);
    check("strobe_onehot", 128'(c_multi), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
